// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, drives the icache iREN/iaddr request, accepts ihit/iload,
// and parks a fetched word in a one-entry skid buffer while IF/ID cannot
// accept it. Hazard controls and the branch/jump redirect come from
// downstream. Priority each cycle: nRST > redirect > flush > stall > load.
module fetch_stage #(
  parameter int                WORD_W   = 32,
  parameter logic [WORD_W-1:0] PC_RESET = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              pc_en,
  input  logic              stall_ifid,
  input  logic              flush_ifid,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  input  logic              ihit,
  input  logic [WORD_W-1:0] iload,
  output logic              ifid_valid,
  output logic [WORD_W-1:0] ifid_instr,
  output logic [WORD_W-1:0] ifid_pc,
  output logic [WORD_W-1:0] ifid_npc,
  output logic [WORD_W-1:0] fetch_cnt
);

  // RUN: request outstanding at r_pc. HOLD: fetched word parked in skid buffer.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam logic [WORD_W-1:0] PC_STEP = WORD_W'(4);

  state_t            r_state;
  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] r_skid_instr;
  logic [WORD_W-1:0] r_skid_pc;
  logic              r_ifid_valid;
  logic [WORD_W-1:0] r_ifid_instr;
  logic [WORD_W-1:0] r_ifid_pc;
  logic [WORD_W-1:0] r_ifid_npc;
  logic [WORD_W-1:0] r_fetch_cnt;

  state_t            w_state_nxt;
  logic [WORD_W-1:0] w_pc_nxt;
  logic              w_skid_load;
  logic              w_ifid_valid_nxt;
  logic [WORD_W-1:0] w_ifid_instr_nxt;
  logic [WORD_W-1:0] w_ifid_pc_nxt;
  logic [WORD_W-1:0] w_ifid_npc_nxt;
  logic [WORD_W-1:0] w_fetch_cnt_nxt;
  logic              w_adv;
  logic [WORD_W-1:0] w_pc_plus4;
  logic [WORD_W-1:0] w_skid_pc_plus4;

  assign w_adv           = pc_en & ~stall_ifid & ~flush_ifid;
  assign w_pc_plus4      = r_pc + PC_STEP;
  assign w_skid_pc_plus4 = r_skid_pc + PC_STEP;

  // Icache request is derived only from registered state, so iaddr moves on edges.
  assign iREN  = (r_state == ST_RUN);
  assign iaddr = r_pc;

  assign ifid_valid = r_ifid_valid;
  assign ifid_instr = r_ifid_instr;
  assign ifid_pc    = r_ifid_pc;
  assign ifid_npc   = r_ifid_npc;
  assign fetch_cnt  = r_fetch_cnt;

  // Next-state, PC, skid-capture and IF/ID selection in priority order.
  always_comb begin
    // NOTE: every output of this block gets a default here so no path infers a latch.
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_skid_load      = 1'b0;
    w_ifid_valid_nxt = r_ifid_valid;
    w_ifid_instr_nxt = r_ifid_instr;
    w_ifid_pc_nxt    = r_ifid_pc;
    w_ifid_npc_nxt   = r_ifid_npc;
    w_fetch_cnt_nxt  = r_fetch_cnt;

    if (redirect_valid) begin
      // Redirect wins: drop any in-flight word and any parked word.
      w_pc_nxt    = {redirect_pc[WORD_W-1:2], 2'b00};
      w_state_nxt = ST_RUN;
      if (!(stall_ifid && !flush_ifid)) begin
        w_ifid_valid_nxt = 1'b0;
        w_ifid_instr_nxt = '0;
        w_ifid_pc_nxt    = '0;
        w_ifid_npc_nxt   = '0;
      end
    end else if (flush_ifid) begin
      // Bubble into IF/ID; a RUN hit is dropped and refetched, HOLD keeps its buffer.
      w_ifid_valid_nxt = 1'b0;
      w_ifid_instr_nxt = '0;
      w_ifid_pc_nxt    = '0;
      w_ifid_npc_nxt   = '0;
    end else if (stall_ifid) begin
      // IF/ID holds; a word arriving now is parked so it is not lost.
      if (r_state == ST_RUN && ihit) begin
        w_skid_load = 1'b1;
        w_state_nxt = ST_HOLD;
      end
    end else if (r_state == ST_RUN) begin
      if (ihit && pc_en) begin
        w_ifid_valid_nxt = 1'b1;
        w_ifid_instr_nxt = iload;
        w_ifid_pc_nxt    = r_pc;
        w_ifid_npc_nxt   = w_pc_plus4;
        w_pc_nxt         = w_pc_plus4;
        w_fetch_cnt_nxt  = r_fetch_cnt + WORD_W'(1);
      end else begin
        // Either no hit yet, or a hit while the PC is frozen (parked for later).
        if (ihit) begin
          w_skid_load = 1'b1;
          w_state_nxt = ST_HOLD;
        end
        w_ifid_valid_nxt = 1'b0;
        w_ifid_instr_nxt = '0;
        w_ifid_pc_nxt    = '0;
        w_ifid_npc_nxt   = '0;
      end
    end else begin
      // HOLD with no flush/stall: deliver the parked word once the PC may advance.
      if (w_adv) begin
        w_ifid_valid_nxt = 1'b1;
        w_ifid_instr_nxt = r_skid_instr;
        w_ifid_pc_nxt    = r_skid_pc;
        w_ifid_npc_nxt   = w_skid_pc_plus4;
        w_pc_nxt         = w_skid_pc_plus4;
        w_state_nxt      = ST_RUN;
        w_fetch_cnt_nxt  = r_fetch_cnt + WORD_W'(1);
      end else begin
        w_ifid_valid_nxt = 1'b0;
        w_ifid_instr_nxt = '0;
        w_ifid_pc_nxt    = '0;
        w_ifid_npc_nxt   = '0;
      end
    end
  end

  // Control state, PC, IF/ID register and counter with synchronous reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!nRST) begin
      r_state      <= ST_RUN;
      r_pc         <= PC_RESET;
      r_ifid_valid <= 1'b0;
      r_ifid_instr <= '0;
      r_ifid_pc    <= '0;
      r_ifid_npc   <= '0;
      r_fetch_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_ifid_valid <= w_ifid_valid_nxt;
      r_ifid_instr <= w_ifid_instr_nxt;
      r_ifid_pc    <= w_ifid_pc_nxt;
      r_ifid_npc   <= w_ifid_npc_nxt;
      r_fetch_cnt  <= w_fetch_cnt_nxt;
    end
  end

  // Skid buffer data capture on a parked hit.
  always_ff @(posedge CLK) begin
    // NOTE: buffer data is not reset; it is only read in HOLD, and reset forces RUN.
    if (w_skid_load && nRST) begin
      r_skid_instr <= iload;
      r_skid_pc    <= r_pc;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage. A second instance with
// PC_RESET = 32'hFFFF_FFFC checks PC wrap. The icache is modelled as
// iload = iaddr ^ KEY with ihit driven directly by each scenario.
module tb_fetch_stage;

  localparam logic [31:0] KEY = 32'h1300_0000;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        pc_en;
  logic        stall_ifid;
  logic        flush_ifid;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ihit;
  logic        sel2;
  logic [31:0] iload;

  logic        iREN, iREN2;
  logic [31:0] iaddr, iaddr2;
  logic        ifid_valid, ifid_valid2;
  logic [31:0] ifid_instr, ifid_instr2;
  logic [31:0] ifid_pc, ifid_pc2;
  logic [31:0] ifid_npc, ifid_npc2;
  logic [31:0] fetch_cnt, fetch_cnt2;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 CLK = ~CLK;

  assign iload = sel2 ? (iaddr2 ^ KEY) : (iaddr ^ KEY);

  fetch_stage #(.WORD_W(32), .PC_RESET(32'h0000_0000)) dut (
    .CLK(CLK), .nRST(nRST), .pc_en(pc_en), .stall_ifid(stall_ifid),
    .flush_ifid(flush_ifid), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .iREN(iREN), .iaddr(iaddr), .ihit(ihit),
    .iload(iload), .ifid_valid(ifid_valid), .ifid_instr(ifid_instr),
    .ifid_pc(ifid_pc), .ifid_npc(ifid_npc), .fetch_cnt(fetch_cnt)
  );

  fetch_stage #(.WORD_W(32), .PC_RESET(32'hFFFF_FFFC)) dut2 (
    .CLK(CLK), .nRST(nRST), .pc_en(pc_en), .stall_ifid(stall_ifid),
    .flush_ifid(flush_ifid), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .iREN(iREN2), .iaddr(iaddr2), .ihit(ihit),
    .iload(iload), .ifid_valid(ifid_valid2), .ifid_instr(ifid_instr2),
    .ifid_pc(ifid_pc2), .ifid_npc(ifid_npc2), .fetch_cnt(fetch_cnt2)
  );

  // One clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic en, input logic st, input logic fl, input logic hit);
    pc_en = en; stall_ifid = st; flush_ifid = fl; ihit = hit;
  endtask

  task automatic do_reset();
    nRST = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    step(); step();
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (iREN !== 1'b1) begin n_mis++; $display("FAIL reset_iren: got %b want 1", iREN); end
    n_cmp++; if (iaddr !== 32'h0) begin n_mis++; $display("FAIL reset_iaddr: got %h want 00000000", iaddr); end
    n_cmp++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || ifid_pc !== 32'h0 || ifid_npc !== 32'h0) begin
      n_mis++; $display("FAIL reset_ifid: got v=%b i=%h p=%h n=%h want all 0", ifid_valid, ifid_instr, ifid_pc, ifid_npc); end
    n_cmp++; if (fetch_cnt !== 32'h0) begin n_mis++; $display("FAIL reset_cnt: got %0d want 0", fetch_cnt); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      exp_pc = 32'(4 * k);
      n_cmp++; if (ifid_valid !== 1'b1 || ifid_pc !== exp_pc || ifid_instr !== (exp_pc ^ KEY) || ifid_npc !== exp_pc + 32'd4) begin
        n_mis++; $display("FAIL stream_ifid[%0d]: got v=%b i=%h p=%h n=%h want v=1 i=%h p=%h n=%h",
                          k, ifid_valid, ifid_instr, ifid_pc, ifid_npc, exp_pc ^ KEY, exp_pc, exp_pc + 32'd4); end
    end
    n_cmp++; if (fetch_cnt !== 32'd3) begin n_mis++; $display("FAIL stream_cnt: got %0d want 3", fetch_cnt); end
    n_cmp++; if (iaddr !== 32'd12) begin n_mis++; $display("FAIL stream_iaddr: got %h want 0000000c", iaddr); end
  endtask

  task automatic test_stall();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    step(); step();                          // pc now 8, IF/ID holds pc 4
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      step();
      n_cmp++; if (iREN !== 1'b0 || iaddr !== 32'd8) begin
        n_mis++; $display("FAIL stall_req[%0d]: got iREN=%b iaddr=%h want iREN=0 iaddr=00000008", k, iREN, iaddr); end
      n_cmp++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'd4 || ifid_instr !== (32'd4 ^ KEY)) begin
        n_mis++; $display("FAIL stall_ifid_hold[%0d]: got v=%b p=%h i=%h want v=1 p=00000004", k, ifid_valid, ifid_pc, ifid_instr); end
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    n_cmp++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'd8 || ifid_instr !== (32'd8 ^ KEY) || ifid_npc !== 32'd12) begin
      n_mis++; $display("FAIL stall_release_ifid: got v=%b i=%h p=%h n=%h want v=1 p=00000008 n=0000000c", ifid_valid, ifid_instr, ifid_pc, ifid_npc); end
    n_cmp++; if (iaddr !== 32'd12 || iREN !== 1'b1 || fetch_cnt !== 32'd3) begin
      n_mis++; $display("FAIL stall_release_pc: got iaddr=%h iREN=%b cnt=%0d want 0000000c 1 3", iaddr, iREN, fetch_cnt); end
  endtask

  task automatic test_redirect();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    step();                                  // pc now 4
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (iaddr !== 32'h100 || ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin
      n_mis++; $display("FAIL redirect: got iaddr=%h v=%b i=%h want 00000100 0 00000000", iaddr, ifid_valid, ifid_instr); end
    n_cmp++; if (fetch_cnt !== 32'd1) begin n_mis++; $display("FAIL redirect_cnt: got %0d want 1", fetch_cnt); end
    step();
    n_cmp++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h100 || ifid_instr !== (32'h100 ^ KEY) || iaddr !== 32'h104) begin
      n_mis++; $display("FAIL redirect_target: got v=%b p=%h i=%h iaddr=%h want 1 00000100 iaddr=00000104", ifid_valid, ifid_pc, ifid_instr, iaddr); end
  endtask

  task automatic test_flush_jump();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) step();      // pc now 16, cnt 4
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    step();
    n_cmp++; if (ifid_valid !== 1'b0 || ifid_pc !== 32'h0 || iaddr !== 32'd16 || iREN !== 1'b1 || fetch_cnt !== 32'd4) begin
      n_mis++; $display("FAIL flush: got v=%b p=%h iaddr=%h iREN=%b cnt=%0d want 0 0 00000010 1 4", ifid_valid, ifid_pc, iaddr, iREN, fetch_cnt); end
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    step();
    n_cmp++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'd16 || iaddr !== 32'd20 || fetch_cnt !== 32'd5) begin
      n_mis++; $display("FAIL flush_refetch: got v=%b p=%h iaddr=%h cnt=%0d want 1 00000010 00000014 5", ifid_valid, ifid_pc, iaddr, fetch_cnt); end
  endtask

  // Continues from pc=20: frozen PC parks a hit; a flush in HOLD keeps the buffer.
  task automatic test_hold_paths();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    step();
    n_cmp++; if (iREN !== 1'b0 || ifid_valid !== 1'b0 || iaddr !== 32'd20) begin
      n_mis++; $display("FAIL pcen_park: got iREN=%b v=%b iaddr=%h want 0 0 00000014", iREN, ifid_valid, iaddr); end
    step();
    n_cmp++; if (iREN !== 1'b0 || ifid_valid !== 1'b0 || fetch_cnt !== 32'd5) begin
      n_mis++; $display("FAIL pcen_hold: got iREN=%b v=%b cnt=%0d want 0 0 5", iREN, ifid_valid, fetch_cnt); end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    n_cmp++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'd20 || ifid_instr !== (32'd20 ^ KEY) || iaddr !== 32'd24 || fetch_cnt !== 32'd6) begin
      n_mis++; $display("FAIL pcen_release: got v=%b p=%h i=%h iaddr=%h cnt=%0d want 1 00000014 iaddr=00000018 6", ifid_valid, ifid_pc, ifid_instr, iaddr, fetch_cnt); end
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    step();                                  // word at 24 parked, IF/ID holds pc 20
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    step();
    n_cmp++; if (ifid_valid !== 1'b0 || iREN !== 1'b0 || iaddr !== 32'd24) begin
      n_mis++; $display("FAIL hold_flush: got v=%b iREN=%b iaddr=%h want 0 0 00000018", ifid_valid, iREN, iaddr); end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    n_cmp++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'd24 || ifid_instr !== (32'd24 ^ KEY) || iaddr !== 32'd28) begin
      n_mis++; $display("FAIL hold_flush_release: got v=%b p=%h i=%h iaddr=%h want 1 00000018 iaddr=0000001c", ifid_valid, ifid_pc, ifid_instr, iaddr); end
    step();                                  // ihit=0 in RUN
    n_cmp++; if (ifid_valid !== 1'b0 || iREN !== 1'b1 || iaddr !== 32'd28) begin
      n_mis++; $display("FAIL no_hit: got v=%b iREN=%b iaddr=%h want 0 1 0000001c", ifid_valid, iREN, iaddr); end
  endtask

  task automatic test_wrap();
    sel2 = 1'b1;
    do_reset();
    n_cmp++; if (iaddr2 !== 32'hFFFF_FFFC) begin n_mis++; $display("FAIL wrap_reset_iaddr: got %h want fffffffc", iaddr2); end
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    step();
    n_cmp++; if (ifid_pc2 !== 32'hFFFF_FFFC || ifid_npc2 !== 32'h0 || ifid_instr2 !== (32'hFFFF_FFFC ^ KEY)) begin
      n_mis++; $display("FAIL wrap_ifid: got p=%h n=%h i=%h want fffffffc 00000000", ifid_pc2, ifid_npc2, ifid_instr2); end
    n_cmp++; if (iaddr2 !== 32'h0 || fetch_cnt2 !== 32'd1) begin
      n_mis++; $display("FAIL wrap_iaddr: got iaddr=%h cnt=%0d want 00000000 1", iaddr2, fetch_cnt2); end
    sel2 = 1'b0;
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    step(); step();                          // pc 8, cnt 2
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    step();
    n_cmp++; if (iREN !== 1'b0) begin n_mis++; $display("FAIL rst_hold_pre: got iREN=%b want 0", iREN); end
    nRST = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    step();
    n_cmp++; if (iREN !== 1'b1 || iaddr !== 32'h0 || ifid_valid !== 1'b0 || fetch_cnt !== 32'h0) begin
      n_mis++; $display("FAIL rst_hold: got iREN=%b iaddr=%h v=%b cnt=%0d want 1 00000000 0 0", iREN, iaddr, ifid_valid, fetch_cnt); end
    nRST = 1'b1;
    step();
    n_cmp++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h0 || ifid_instr !== KEY) begin
      n_mis++; $display("FAIL rst_hold_restart: got v=%b p=%h i=%h want 1 00000000 %h", ifid_valid, ifid_pc, ifid_instr, KEY); end
  endtask

  initial begin
    sel2 = 1'b0;
    nRST = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_flush_jump();
    test_hold_paths();
    test_wrap();
    test_reset_in_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
